// File: rtl/sd_controller_wb.sv
// sd_controller_wb: Wishbone B3 classic slave register file for the SD
// controller. It holds the command, configuration and DMA registers that feed
// the command and data engines, returns the engine response and status words
// on reads, and issues one-cycle strobes for command start and for clearing
// the interrupt status.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   wb_* (dat/adr/sel/we/cyc/stb/ack)  Wishbone classic slave
//   cmd_start, cmd_int_rst, data_int_rst  one-cycle strobes, coincident with ack
//   *_reg outputs              stored register values for the engines
//   response_*_reg, *_int_status_reg  engine values returned on reads
module sd_controller_wb #(
  parameter int CMD_REG_SIZE     = 14,
  parameter int BLKSIZE_W        = 12,
  parameter int BLKCNT_W         = 16,
  parameter int INT_CMD_SIZE     = 5,
  parameter int INT_DATA_SIZE    = 3,
  parameter int RESET_BLOCK_SIZE = 511,
  parameter int RESET_CLK_DIV    = 0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [31:0]              wb_dat_i,
  output logic [31:0]              wb_dat_o,
  input  logic [7:0]               wb_adr_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic                     wb_ack_o,
  output logic                     cmd_start,
  output logic                     data_int_rst,
  output logic                     cmd_int_rst,
  output logic [31:0]              argument_reg,
  output logic [CMD_REG_SIZE-1:0]  command_reg,
  input  logic [31:0]              response_0_reg,
  input  logic [31:0]              response_1_reg,
  input  logic [31:0]              response_2_reg,
  input  logic [31:0]              response_3_reg,
  output logic                     software_reset_reg,
  output logic [15:0]              timeout_reg,
  output logic [BLKSIZE_W-1:0]     block_size_reg,
  output logic [15:0]              controll_setting_reg,
  input  logic [INT_CMD_SIZE-1:0]  cmd_int_status_reg,
  output logic [INT_CMD_SIZE-1:0]  cmd_int_enable_reg,
  output logic [7:0]               clock_divider_reg,
  output logic [BLKCNT_W-1:0]      block_count_reg,
  output logic [31:0]              dma_addr_reg,
  input  logic [INT_DATA_SIZE-1:0] data_int_status_reg,
  output logic [INT_DATA_SIZE-1:0] data_int_enable_reg
);

  logic                     r_ack;
  logic [31:0]              r_dat;
  logic                     r_cmd_start;
  logic                     r_cmd_int_rst;
  logic                     r_data_int_rst;
  logic [31:0]              r_argument;
  logic [CMD_REG_SIZE-1:0]  r_command;
  logic                     r_soft_reset;
  logic [15:0]              r_timeout;
  logic [BLKSIZE_W-1:0]     r_block_size;
  logic [15:0]              r_ctrl;
  logic [INT_CMD_SIZE-1:0]  r_cmd_int_en;
  logic [7:0]               r_clk_div;
  logic [BLKCNT_W-1:0]      r_block_count;
  logic [31:0]              r_dma_addr;
  logic [INT_DATA_SIZE-1:0] r_data_int_en;

  logic        w_access;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_rd_data;

  // The ack term blocks a second access on the edge right after an ack, which
  // gives the one-access-per-two-cycles behaviour of classic Wishbone.
  assign w_access = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr     = w_access & wb_we_i;
  assign w_rd     = w_access & ~wb_we_i;

  // Byte-lane merge on a zero-extended view of the register; the caller
  // truncates the result back to the register width.
  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] dat,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[i*8 +: 8] = dat[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    w_rd_data = '0;
    case (wb_adr_i)
      8'h00: w_rd_data = r_argument;
      8'h04: w_rd_data = 32'(r_command);
      8'h08: w_rd_data = response_0_reg;
      8'h0C: w_rd_data = response_1_reg;
      8'h10: w_rd_data = response_2_reg;
      8'h14: w_rd_data = response_3_reg;
      8'h1C: w_rd_data = 32'(r_ctrl);
      8'h20: w_rd_data = 32'(r_timeout);
      8'h24: w_rd_data = 32'(r_clk_div);
      8'h28: w_rd_data = 32'(r_soft_reset);
      8'h2C: w_rd_data = 32'h0000_000F;
      8'h30: w_rd_data = 32'h0000_0000;
      8'h34: w_rd_data = 32'(cmd_int_status_reg);
      8'h38: w_rd_data = 32'(r_cmd_int_en);
      8'h3C: w_rd_data = 32'(data_int_status_reg);
      8'h40: w_rd_data = 32'(r_data_int_en);
      8'h44: w_rd_data = 32'(r_block_size);
      8'h48: w_rd_data = 32'(r_block_count);
      8'h60: w_rd_data = r_dma_addr;
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack          <= 1'b0;
      r_dat          <= '0;
      r_cmd_start    <= 1'b0;
      r_cmd_int_rst  <= 1'b0;
      r_data_int_rst <= 1'b0;
      r_argument     <= '0;
      r_command      <= '0;
      r_soft_reset   <= 1'b0;
      r_timeout      <= '0;
      r_block_size   <= BLKSIZE_W'(RESET_BLOCK_SIZE);
      r_ctrl         <= '0;
      r_cmd_int_en   <= '0;
      r_clk_div      <= 8'(RESET_CLK_DIV);
      r_block_count  <= '0;
      r_dma_addr     <= '0;
      r_data_int_en  <= '0;
    end else begin
      r_ack          <= w_access;
      r_cmd_start    <= 1'b0;
      r_cmd_int_rst  <= 1'b0;
      r_data_int_rst <= 1'b0;
      if (w_rd) r_dat <= w_rd_data;
      if (w_wr) begin
        case (wb_adr_i)
          8'h00: begin
            r_argument  <= f_merge(r_argument, wb_dat_i, wb_sel_i);
            r_cmd_start <= 1'b1;
          end
          8'h04: r_command     <= CMD_REG_SIZE'(f_merge(32'(r_command), wb_dat_i, wb_sel_i));
          8'h1C: r_ctrl        <= 16'(f_merge(32'(r_ctrl), wb_dat_i, wb_sel_i));
          8'h20: r_timeout     <= 16'(f_merge(32'(r_timeout), wb_dat_i, wb_sel_i));
          8'h24: r_clk_div     <= 8'(f_merge(32'(r_clk_div), wb_dat_i, wb_sel_i));
          8'h28: r_soft_reset  <= 1'(f_merge(32'(r_soft_reset), wb_dat_i, wb_sel_i));
          8'h34: r_cmd_int_rst <= 1'b1;
          8'h38: r_cmd_int_en  <= INT_CMD_SIZE'(f_merge(32'(r_cmd_int_en), wb_dat_i, wb_sel_i));
          8'h3C: r_data_int_rst <= 1'b1;
          8'h40: r_data_int_en <= INT_DATA_SIZE'(f_merge(32'(r_data_int_en), wb_dat_i, wb_sel_i));
          8'h44: r_block_size  <= BLKSIZE_W'(f_merge(32'(r_block_size), wb_dat_i, wb_sel_i));
          8'h48: r_block_count <= BLKCNT_W'(f_merge(32'(r_block_count), wb_dat_i, wb_sel_i));
          8'h60: r_dma_addr    <= f_merge(r_dma_addr, wb_dat_i, wb_sel_i);
          default: ;
        endcase
      end
    end
  end

  assign wb_ack_o             = r_ack;
  assign wb_dat_o             = r_dat;
  assign cmd_start            = r_cmd_start;
  assign cmd_int_rst          = r_cmd_int_rst;
  assign data_int_rst         = r_data_int_rst;
  assign argument_reg         = r_argument;
  assign command_reg          = r_command;
  assign software_reset_reg   = r_soft_reset;
  assign timeout_reg          = r_timeout;
  assign block_size_reg       = r_block_size;
  assign controll_setting_reg = r_ctrl;
  assign cmd_int_enable_reg   = r_cmd_int_en;
  assign clock_divider_reg    = r_clk_div;
  assign block_count_reg      = r_block_count;
  assign dma_addr_reg         = r_dma_addr;
  assign data_int_enable_reg  = r_data_int_en;

endmodule

// File: tb/tb_sd_controller_wb.sv
// Testbench for sd_controller_wb: directed register-map scenarios plus random
// Wishbone traffic checked against a register-map model.
module tb_sd_controller_wb;

  localparam int CMD_REG_SIZE  = 14;
  localparam int BLKSIZE_W     = 12;
  localparam int BLKCNT_W      = 16;
  localparam int INT_CMD_SIZE  = 5;
  localparam int INT_DATA_SIZE = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [31:0]              wb_dat_i;
  logic [31:0]              wb_dat_o;
  logic [7:0]               wb_adr_i;
  logic [3:0]               wb_sel_i;
  logic                     wb_we_i;
  logic                     wb_cyc_i;
  logic                     wb_stb_i;
  logic                     wb_ack_o;
  logic                     cmd_start;
  logic                     data_int_rst;
  logic                     cmd_int_rst;
  logic [31:0]              argument_reg;
  logic [CMD_REG_SIZE-1:0]  command_reg;
  logic [31:0]              resp0, resp1, resp2, resp3;
  logic                     software_reset_reg;
  logic [15:0]              timeout_reg;
  logic [BLKSIZE_W-1:0]     block_size_reg;
  logic [15:0]              controll_setting_reg;
  logic [INT_CMD_SIZE-1:0]  cmd_sts;
  logic [INT_CMD_SIZE-1:0]  cmd_int_enable_reg;
  logic [7:0]               clock_divider_reg;
  logic [BLKCNT_W-1:0]      block_count_reg;
  logic [31:0]              dma_addr_reg;
  logic [INT_DATA_SIZE-1:0] data_sts;
  logic [INT_DATA_SIZE-1:0] data_int_enable_reg;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [0:255];
  logic [31:0] last_rd;
  logic [7:0]  rw_addrs [11] = '{8'h00, 8'h04, 8'h1C, 8'h20, 8'h24, 8'h28,
                                 8'h38, 8'h40, 8'h44, 8'h48, 8'h60};
  logic [7:0]  any_addrs [24] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                                  8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C,
                                  8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44,
                                  8'h48, 8'h4C, 8'h60, 8'h64, 8'hFC, 8'h02};

  always #5 clk = ~clk;

  sd_controller_wb dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .cmd_start(cmd_start), .data_int_rst(data_int_rst), .cmd_int_rst(cmd_int_rst),
    .argument_reg(argument_reg), .command_reg(command_reg),
    .response_0_reg(resp0), .response_1_reg(resp1),
    .response_2_reg(resp2), .response_3_reg(resp3),
    .software_reset_reg(software_reset_reg), .timeout_reg(timeout_reg),
    .block_size_reg(block_size_reg), .controll_setting_reg(controll_setting_reg),
    .cmd_int_status_reg(cmd_sts), .cmd_int_enable_reg(cmd_int_enable_reg),
    .clock_divider_reg(clock_divider_reg), .block_count_reg(block_count_reg),
    .dma_addr_reg(dma_addr_reg), .data_int_status_reg(data_sts),
    .data_int_enable_reg(data_int_enable_reg)
  );

  // Writable width of each RW register; zero marks a non-writable address.
  function automatic logic [31:0] wmask(input logic [7:0] a);
    case (a)
      8'h00, 8'h60: return 32'hFFFF_FFFF;
      8'h04:        return 32'h0000_3FFF;
      8'h1C, 8'h20, 8'h48: return 32'h0000_FFFF;
      8'h24:        return 32'h0000_00FF;
      8'h28:        return 32'h0000_0001;
      8'h38:        return 32'h0000_001F;
      8'h40:        return 32'h0000_0007;
      8'h44:        return 32'h0000_0FFF;
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] dut_out(input logic [7:0] a);
    case (a)
      8'h00: return argument_reg;
      8'h04: return 32'(command_reg);
      8'h1C: return 32'(controll_setting_reg);
      8'h20: return 32'(timeout_reg);
      8'h24: return 32'(clock_divider_reg);
      8'h28: return 32'(software_reset_reg);
      8'h38: return 32'(cmd_int_enable_reg);
      8'h40: return 32'(data_int_enable_reg);
      8'h44: return 32'(block_size_reg);
      8'h48: return 32'(block_count_reg);
      8'h60: return dma_addr_reg;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    if (wmask(a) != 0) return mdl[a];
    case (a)
      8'h08: return resp0;
      8'h0C: return resp1;
      8'h10: return resp2;
      8'h14: return resp3;
      8'h2C: return 32'h0000_000F;
      8'h34: return 32'(cmd_sts);
      8'h3C: return 32'(data_sts);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
    mdl[8'h44] = 32'd511;
    last_rd = 32'h0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] bm;
    for (int i = 0; i < 4; i++) bm[i*8 +: 8] = {8{s[i]}};
    if (wmask(a) != 0) mdl[a] = ((mdl[a] & ~bm) | (d & bm)) & wmask(a);
  endtask

  // One classic access; samples the ack edge and the edge after it.
  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic we, output logic ack1, output logic ack2,
                     output logic [31:0] rd, output logic [2:0] st1, output logic [2:0] st2);
    @(negedge clk);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    ack1 = wb_ack_o; rd = wb_dat_o; st1 = {cmd_start, cmd_int_rst, data_int_rst};
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    ack2 = wb_ack_o; st2 = {cmd_start, cmd_int_rst, data_int_rst};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
    resp0 = 0; resp1 = 0; resp2 = 0; resp3 = 0; cmd_sts = 0; data_sts = 0;
    model_reset();
    #12;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    foreach (rw_addrs[i]) begin
      checks++;
      if (dut_out(rw_addrs[i]) !== mdl[rw_addrs[i]]) begin
        failures++;
        $display("FAIL reset_val addr=%h got=%h exp=%h", rw_addrs[i], dut_out(rw_addrs[i]), mdl[rw_addrs[i]]);
      end
    end
    checks++;
    if ({wb_ack_o, cmd_start, cmd_int_rst, data_int_rst, wb_dat_o} !== 36'h0) begin
      failures++;
      $display("FAIL reset_bus got ack=%b strb=%b%b%b dat=%h exp all 0",
               wb_ack_o, cmd_start, cmd_int_rst, data_int_rst, wb_dat_o);
    end
  endtask

  task automatic test_directed();
    logic a1, a2; logic [31:0] rd; logic [2:0] s1, s2;
    logic [7:0]  wa [10] = '{8'h04, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h38, 8'h40, 8'h44, 8'h48, 8'h60};
    logic [31:0] wd [10] = '{32'h0405, 32'h0A0B, 32'h0B0C, 32'h0D, 32'h1, 32'h15, 32'h5,
                             32'hABC, 32'h1011, 32'h11121314};
    logic [7:0]  ra [4] = '{8'h08, 8'h0C, 8'h10, 8'h14};
    logic [31:0] rv [4] = '{32'h04050607, 32'h05060708, 32'h06070809, 32'h0708090A};

    bus(8'h00, 32'h01020304, 4'hF, 1'b1, a1, a2, rd, s1, s2);
    model_write(8'h00, 32'h01020304, 4'hF);
    checks++;
    if ({a1, a2, s1, s2} !== 8'b10_100_000) begin
      failures++;
      $display("FAIL arg_handshake got ack=%b%b strb=%b/%b exp ack=10 strb=100/000", a1, a2, s1, s2);
    end
    checks++;
    if (argument_reg !== 32'h01020304) begin
      failures++; $display("FAIL arg_value got=%h exp=01020304", argument_reg);
    end

    resp0 = rv[0]; resp1 = rv[1]; resp2 = rv[2]; resp3 = rv[3];
    foreach (ra[i]) begin
      bus(ra[i], 32'h0, 4'hF, 1'b0, a1, a2, rd, s1, s2);
      checks++;
      if (a1 !== 1'b1 || rd !== rv[i]) begin
        failures++; $display("FAIL resp_read addr=%h got=%h ack=%b exp=%h", ra[i], rd, a1, rv[i]);
      end
    end

    foreach (wa[i]) begin
      bus(wa[i], wd[i], 4'hF, 1'b1, a1, a2, rd, s1, s2);
      model_write(wa[i], wd[i], 4'hF);
      checks++;
      if (dut_out(wa[i]) !== wd[i]) begin
        failures++; $display("FAIL cfg_write addr=%h got=%h exp=%h", wa[i], dut_out(wa[i]), wd[i]);
      end
    end

    bus(8'h2C, 32'hFFFF_FFFF, 4'hF, 1'b0, a1, a2, rd, s1, s2);
    checks++;
    if (rd !== 32'h0F) begin failures++; $display("FAIL voltage got=%h exp=0000000f", rd); end
    bus(8'h30, 32'h0, 4'hF, 1'b0, a1, a2, rd, s1, s2);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL capa got=%h exp=00000000", rd); end

    bus(8'h34, 32'hFFFF_FFFF, 4'hF, 1'b1, a1, a2, rd, s1, s2);
    checks++;
    if ({s1, s2} !== 6'b010_000) begin
      failures++; $display("FAIL cmd_isr_clr got strb=%b/%b exp=010/000", s1, s2);
    end
    bus(8'h3C, 32'hFFFF_FFFF, 4'hF, 1'b1, a1, a2, rd, s1, s2);
    checks++;
    if ({s1, s2} !== 6'b001_000) begin
      failures++; $display("FAIL data_isr_clr got strb=%b/%b exp=001/000", s1, s2);
    end
    cmd_sts = 5'h1A; data_sts = 3'h6;
    bus(8'h34, 32'h0, 4'hF, 1'b0, a1, a2, rd, s1, s2);
    checks++;
    if (rd !== 32'h1A) begin failures++; $display("FAIL cmd_isr_read got=%h exp=0000001a", rd); end
    bus(8'h3C, 32'h0, 4'hF, 1'b0, a1, a2, rd, s1, s2);
    checks++;
    if (rd !== 32'h6) begin failures++; $display("FAIL data_isr_read got=%h exp=00000006", rd); end
    last_rd = 32'h6;
  endtask

  // cyc/stb held high: ack must alternate, and each ack is a separate write.
  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    logic [2:0] got;
    d1 = $urandom; d2 = $urandom;
    @(negedge clk);
    wb_adr_i = 8'h00; wb_dat_i = d1; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    got[2] = wb_ack_o & cmd_start;
    wb_dat_i = d2;
    @(posedge clk); #1;
    got[1] = wb_ack_o | cmd_start;
    @(posedge clk); #1;
    got[0] = wb_ack_o & cmd_start;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    model_write(8'h00, d2, 4'hF);
    checks++;
    if (got !== 3'b101) begin
      failures++; $display("FAIL b2b_ack_pattern got=%b exp=101", got);
    end
    checks++;
    if (argument_reg !== d2) begin
      failures++; $display("FAIL b2b_value got=%h exp=%h", argument_reg, d2);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_ack got=%b exp=0", wb_ack_o); end
  endtask

  task automatic test_random(input int n);
    logic a1, a2; logic [31:0] rd, d, e; logic [2:0] s1, s2, es; logic [7:0] a;
    logic [3:0] s; logic we;
    for (int it = 0; it < n; it++) begin
      resp0 = $urandom; resp1 = $urandom; resp2 = $urandom; resp3 = $urandom;
      cmd_sts = INT_CMD_SIZE'($urandom); data_sts = INT_DATA_SIZE'($urandom);
      a  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : any_addrs[$urandom_range(0, 23)];
      d  = $urandom; s = 4'($urandom); we = 1'($urandom);
      e  = exp_read(a);
      es = {we && a == 8'h00, we && a == 8'h34, we && a == 8'h3C};
      bus(a, d, s, we, a1, a2, rd, s1, s2);
      checks++;
      if ({a1, a2, s1, s2} !== {2'b10, es, 3'b000}) begin
        failures++;
        $display("FAIL rnd_handshake it=%0d addr=%h we=%b got ack=%b%b strb=%b/%b exp ack=10 strb=%b/000",
                 it, a, we, a1, a2, s1, s2, es);
      end
      if (we) begin
        model_write(a, d, s);
        checks++;
        if (rd !== last_rd) begin
          failures++; $display("FAIL rnd_dat_hold it=%0d got=%h exp=%h", it, rd, last_rd);
        end
        if (wmask(a) != 0) begin
          checks++;
          if (dut_out(a) !== mdl[a]) begin
            failures++; $display("FAIL rnd_write it=%0d addr=%h got=%h exp=%h", it, a, dut_out(a), mdl[a]);
          end
        end
      end else begin
        last_rd = e;
        checks++;
        if (rd !== e) begin
          failures++; $display("FAIL rnd_read it=%0d addr=%h got=%h exp=%h", it, a, rd, e);
        end
      end
    end
    foreach (rw_addrs[i]) begin
      checks++;
      if (dut_out(rw_addrs[i]) !== mdl[rw_addrs[i]]) begin
        failures++;
        $display("FAIL rnd_final addr=%h got=%h exp=%h", rw_addrs[i], dut_out(rw_addrs[i]), mdl[rw_addrs[i]]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    wb_adr_i = 8'h00; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({wb_ack_o, cmd_start} !== 2'b11) begin
      failures++; $display("FAIL mid_rst_pre got ack/start=%b%b exp=11", wb_ack_o, cmd_start);
    end
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({wb_ack_o, cmd_start, argument_reg} !== 34'h0 || block_size_reg !== 12'd511) begin
      failures++;
      $display("FAIL mid_rst got ack=%b start=%b arg=%h blk=%0d exp ack=0 start=0 arg=0 blk=511",
               wb_ack_o, cmd_start, argument_reg, block_size_reg);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    foreach (rw_addrs[i]) begin
      checks++;
      if (dut_out(rw_addrs[i]) !== mdl[rw_addrs[i]]) begin
        failures++;
        $display("FAIL mid_rst_val addr=%h got=%h exp=%h", rw_addrs[i], dut_out(rw_addrs[i]), mdl[rw_addrs[i]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random(400);
    test_reset_mid_access();
    test_random(100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
